// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin arbiter that shares one multi-cycle ALU between
// NUM_REQ requesters, rejecting illegal modes locally and aborting stalled
// operations with a watchdog.
module alu_scheduler #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_A,
  input  logic [32*NUM_REQ-1:0] req_B,
  input  logic [4*NUM_REQ-1:0]  req_mode,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [63:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  alu_valid,
  output logic [31:0]           alu_A,
  output logic [31:0]           alu_B,
  output logic [3:0]            alu_mode,
  input  logic                  alu_ready,
  input  logic [63:0]           alu_out,
  output logic                  busy
);

  localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W    = IDX_W + 1;
  localparam int unsigned CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [3:0]  MAX_MODE = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   grant_c;
  logic [IDX_W-1:0]   grant_d;
  logic               found_c;
  logic               accept_c;
  logic               timeout_c;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        a_sel_c;
  logic [31:0]        b_sel_c;
  logic [3:0]         mode_sel_c;
  logic [NUM_REQ-1:0] rsp_valid_d;

  // Cyclic priority search for the first valid requester starting at ptr.
  always_comb begin
    logic [SUM_W-1:0] sum;
    sum     = '0;
    grant_c = '0;
    found_c = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = SUM_W'(ptr_q) + SUM_W'(k);
      if (sum >= SUM_W'(NUM_REQ)) begin
        sum = sum - SUM_W'(NUM_REQ);
      end
      if (!found_c && req_valid[sum[IDX_W-1:0]]) begin
        found_c = 1'b1;
        grant_c = sum[IDX_W-1:0];
      end
    end
  end

  // Operand mux for the current winner.
  always_comb begin
    a_sel_c    = '0;
    b_sel_c    = '0;
    mode_sel_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_c == IDX_W'(k)) begin
        a_sel_c    = req_A[32*k +: 32];
        b_sel_c    = req_B[32*k +: 32];
        mode_sel_c = req_mode[4*k +: 4];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, combinational accept handshake and next output values.
  always_comb begin
    state_d     = state_q;
    req_ready   = '0;
    accept_c    = 1'b0;
    timeout_c   = (cnt_q == CNT_W'(TIMEOUT - 1));
    grant_d     = grant_q;
    rsp_valid_d = '0;
    case (state_q)
      S_IDLE: begin
        if (found_c) begin
          req_ready[grant_c] = 1'b1;
          accept_c           = 1'b1;
          grant_d            = grant_c;
          state_d            = (mode_sel_c > MAX_MODE) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (alu_ready || timeout_c) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_RESP) begin
      rsp_valid_d[grant_d] = 1'b1;
    end
  end

  // Datapath: operand latch, watchdog, response register, round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      alu_A     <= '0;
      alu_B     <= '0;
      alu_mode  <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rsp_valid <= '0;
      alu_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid_d;
      alu_valid <= (state_d == S_ISSUE);
      busy      <= (state_d != S_IDLE);
      if (accept_c) begin
        alu_A    <= a_sel_c;
        alu_B    <= b_sel_c;
        alu_mode <= mode_sel_c;
        grant_q  <= grant_c;
        if (mode_sel_c > MAX_MODE) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
      if (state_q == S_ISSUE) begin
        cnt_q <= '0;
      end else if (state_q == S_WAIT && !alu_ready) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // A result arriving on the expiry cycle still counts as success.
      if (state_q == S_WAIT) begin
        if (alu_ready) begin
          rsp_data <= alu_out;
          rsp_err  <= 1'b0;
        end else if (timeout_c) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
      if (state_q == S_RESP) begin
        ptr_q <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
      end
    end
  end

endmodule
